serial_comparator_4: RTL

SERIAL_COMPARATOR_4 -- requirements
Module: serial_comparator_4

---
 rtl/serial_comparator_4_pkg.sv | 9 +
 rtl/serial_comparator_4_if.sv | 13 +
 rtl/serial_comparator_4_cmp.sv | 8 +
 rtl/serial_comparator_4.sv | 75 +++++++
 4 files changed

// File: rtl/serial_comparator_4_pkg.sv
// serial_comparator_4_pkg: shared FSM state encoding and default operand width.
package serial_comparator_4_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/serial_comparator_4_if.sv
// serial_comparator_4_if: request/result bundle between a requester and the serial comparator.
interface serial_comparator_4_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;
   modport master (output start, a, b, input busy, done, eq, gt, lt);
   modport slave  (input start, a, b, output busy, done, eq, gt, lt);
endinterface

// File: rtl/serial_comparator_4_cmp.sv
// comparator_1: single-bit equality cell.
module comparator_1 (
   input  logic i0,
   input  logic i1,
   output logic eq
);
   assign eq = ~(i0 ^ i1);
endmodule

// File: rtl/serial_comparator_4.sv
// serial_comparator_4: LSB-first bit-serial unsigned magnitude comparator with registered results.
module serial_comparator_4
   import serial_comparator_4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                  clk,
   input logic                  rst,
   serial_comparator_4_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CW-1:0]    cnt_q;
   logic             eq_acc_q, gt_acc_q, lt_acc_q;
   logic             eq_acc_d, gt_acc_d, lt_acc_d;
   logic             busy_q, done_q, eq_q, gt_q, lt_q;
   logic             bit_eq, last;
   comparator_1 u_cmp (.i0(a_q[0]), .i1(b_q[0]), .eq(bit_eq));
   // later (more significant) differing bits overwrite earlier ones
   assign eq_acc_d = eq_acc_q & bit_eq;
   assign gt_acc_d = bit_eq ? gt_acc_q : a_q[0];
   assign lt_acc_d = bit_eq ? lt_acc_q : b_q[0];
   assign last     = cnt_q == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         eq_acc_q <= 1'b0;
         gt_acc_q <= 1'b0;
         lt_acc_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else if (state_q == SHIFT) begin
         a_q      <= a_q >> 1;
         b_q      <= b_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         eq_acc_q <= eq_acc_d;
         gt_acc_q <= gt_acc_d;
         lt_acc_q <= lt_acc_d;
         if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= eq_acc_d;
            gt_q    <= gt_acc_d;
            lt_q    <= lt_acc_d;
         end
      end else if (bus.start) begin
         state_q  <= SHIFT;
         a_q      <= bus.a;
         b_q      <= bus.b;
         cnt_q    <= '0;
         eq_acc_q <= 1'b1;
         gt_acc_q <= 1'b0;
         lt_acc_q <= 1'b0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.eq   = eq_q;
   assign bus.gt   = gt_q;
   assign bus.lt   = lt_q;
endmodule
